// File: rtl/dmem_wait_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [15:0] acc_count;

  // MEM stage side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall, acc_count
  );

  // Responder side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall, acc_count
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the MEM stage: accepts one request at a time,
// waits LAT cycles, performs the word access and returns a one-cycle response.
// The memory array itself is never reset.
module dmem_wait_responder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dmem_wait_responder_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [15:0]         acc_count_q, acc_count_d;
  logic                mem_we;
  logic                addr_err;

  logic [31:0] mem_q [DEPTH];

  // Misaligned word or any address bit above the memory range.
  always_comb begin
    addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:ADDR_W+2] != '0);
  end

  // Next-state, request latching and response generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    acc_count_d  = acc_count_q;
    mem_we       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[ADDR_W+1:2];
          wdata_d = bus.req_wdata;
          if (addr_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : mem_q[idx_q];
          mem_we       = we_q;
          if (acc_count_q != 16'hFFFF) begin
            acc_count_d = acc_count_q + 16'd1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      acc_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      acc_count_q  <= acc_count_d;
    end
  end

  // Store commit; a reset on the commit edge discards the store.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Handshake and hazard-unit outputs.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.stall      = (state_q == S_WAIT) || ((state_q == S_IDLE) && bus.req_valid);
    bus.resp_valid = resp_valid_q;
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    bus.acc_count  = acc_count_q;
  end

endmodule
